alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single registered ALU (alu_control/a/b in, result/zero out, both registered on clk) among
//  NREQ requesters. Round-robin grant, operand capture, sequencing of the ALU's two-edge result/zero
//  latency, and return of a tagged response. Sits between issue logic and the ALU instance.
// PARAMETERS
//  WIDTH  32  operand/result width; matches ALU a/b/result
//  NREQ   4   number of requesters, 2..8
//  IDW    2   requester-id width, $clog2(NREQ)
// PORTS
//  clk          in   1           clock; all state updates on posedge
//  rst          in   1           synchronous, active-high reset
//  req_valid    in   NREQ        requester i has an op pending; held until accepted
//  req_ready    out  NREQ        one-hot accept; req i accepted on edge where valid[i]&ready[i]
//  req_op       in   NREQ*3      per-requester alu_control code, slice i = [3i+2:3i]
//  req_a        in   NREQ*WIDTH  per-requester operand a
//  req_b        in   NREQ*WIDTH  per-requester operand b
//  rsp_valid    out  1           response available; held until rsp_ready
//  rsp_ready    in   1           consumer takes response on edge where rsp_valid&rsp_ready
//  rsp_id       out  IDW         index of requester that owns the response
//  rsp_result   out  WIDTH       ALU result
//  rsp_zero     out  1           ALU zero flag for this result
//  rsp_err      out  1           illegal opcode (see CONFIGURATION); else 0
//  alu_a/alu_b  out  WIDTH       to ALU a/b
//  alu_control  out  3           to ALU alu_control
//  alu_result   in   WIDTH       from ALU result
//  alu_zero     in   1           from ALU zero
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=0; rsp_valid=0; rsp_id/result/zero/err=0; alu_a/b/control=0;
//   RR pointer=NREQ-1 (requester 0 wins first). In-flight op discarded; ALU regs not reset, ignored.
//  FSM IDLE->EXEC->FLAG->RESP->IDLE.
//  IDLE: req_ready = one-hot of first valid searching ptr+1, ptr+2, .. mod NREQ (comb from req_valid).
//   On accept: latch op/a/b/id into alu_* / id regs, ptr<=winner, ->EXEC. No valid: stay.
//  EXEC: alu_* stable; ALU registers result on this edge. ->FLAG.
//  FLAG: alu_* stable; ALU registers zero (from result) on this edge. ->RESP.
//  RESP: rsp_valid=1, rsp_result=alu_result, rsp_zero=alu_zero (alu_* still held, so both stable).
//   On rsp_ready edge ->IDLE, rsp_valid drops next cycle. Stall indefinitely otherwise.
//  Latency: accept edge at cycle 0 -> rsp_valid high in cycle 3. Back-to-back throughput: 1 op / 4 cycles.
//  req_ready is 0 in every state but IDLE; no new accept in the cycle rsp is consumed.
//  Simultaneous valids: exactly one granted; un-granted ones must hold. Winner of last grant
//   is lowest priority next time. Valid dropped before accept is permitted (no effect).
//  Opcode passthrough unchanged; result width/wrap is ALU's (MUL truncated to WIDTH).
//  rst asserted in any state wins over all other events on that edge.
// CONFIGURATION
//  ALU_ARB_ILLEGAL_OP_EN defined: ops 3'b011/100/101 detected at accept; ALU not driven
//   (alu_control=0 held from prior value irrelevant), FSM IDLE->RESP directly; rsp_err=1,
//   rsp_result=0, rsp_zero=1; latency 1 cycle. Legal ops: rsp_err=0.
//  Undefined: all ops go through ALU (illegal yields result 0, zero 1); rsp_err tied 0.
// STRUCTURE
//  Package alu_arb_pkg: opcode localparams (OP_AND=000, OP_OR=001, OP_ADD=010, OP_SUB=110,
//   OP_MUL=111), state encoding enum (IDLE, EXEC, FLAG, RESP), is_legal_op function.
//  Sub-module rr_arbiter #(NREQ): req vector + ptr -> one-hot grant + encoded index; combinational.
//  Top holds FSM, operand/id registers, response mux.
// TESTING
//  1 Single op: req0 ADD a=5 b=7 -> req_ready[0] cycle 0, rsp_valid cycle 3, result=12 zero=0 id=0.
//  2 Zero flag: req1 SUB a=9 b=9 -> result=0 zero=1; then AND 0xF0&0x0F -> result=0 zero=1,
//    then OR 1|0 -> zero=0 (zero must track current op, not previous).
//  3 Fairness: all 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; one accept per 4 cycles.
//  4 Backpressure: rsp_ready=0 for 10 cycles on MUL 3*4 -> rsp_valid/result=12 held stable, req_ready=0
//    throughout; release -> IDLE, next accept the following cycle.
//  5 Reset mid-op: rst in FLAG -> next cycle all outputs 0, state IDLE; next grant goes to req 0.
//  6 ALU_ARB_ILLEGAL_OP_EN: op=3'b100 -> rsp_valid cycle 1, err=1 result=0 zero=1;
//    without macro -> cycle 3, err=0 result=0 zero=1.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared opcodes, FSM state encoding and opcode legality check for alu_arbiter.
package alu_arb_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        FLAG = 2'd2,
        RESP = 2'd3
    } state_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, wrapping, as one-hot and index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_vld
);

    logic [IDW:0]      rot_sh;
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;

    // Rotate so that rot[0] is the requester right after ptr; the first set bit wins.
    always_comb begin
        rot_sh = {1'b0, ptr} + 1'b1;
        dbl    = {req, req} >> rot_sh;
        rot    = dbl[NREQ-1:0];
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_vld && rot[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDW'((int'(ptr) + 1 + k) % NREQ);
            end
        end
        gnt = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one registered ALU among NREQ requesters, tagged responses.
// Optional ALU_ARB_ILLEGAL_OP_EN: illegal opcodes bypass the ALU and return an error response.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*3-1:0]     req_op,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_err,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [2:0]            alu_control,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_zero
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_control_q, alu_control_d;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic             err_q, err_d;
`endif

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_vld;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign req_ready = (state_q == IDLE) ? gnt : '0;

    // One-hot mux of the granted requester's payload.
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_op = req_op[3*i +: 3];
                sel_a  = req_a[WIDTH*i +: WIDTH];
                sel_b  = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        id_d          = id_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_control_d = alu_control_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
        err_d         = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    ptr_d = gnt_idx;
                    id_d  = gnt_idx;
`ifdef ALU_ARB_ILLEGAL_OP_EN
                    if (!is_legal_op(sel_op)) begin
                        // ALU inputs are left untouched; the response is synthesized locally.
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d         = 1'b0;
                        alu_a_d       = sel_a;
                        alu_b_d       = sel_b;
                        alu_control_d = sel_op;
                        state_d       = EXEC;
                    end
`else
                    alu_a_d       = sel_a;
                    alu_b_d       = sel_b;
                    alu_control_d = sel_op;
                    state_d       = EXEC;
`endif
                end
            end
            EXEC:    state_d = FLAG;
            FLAG:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= IDW'(NREQ - 1);
            id_q          <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_control_q <= '0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            id_q          <= id_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_control_q <= alu_control_d;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            err_q         <= err_d;
`endif
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_control_q;

    // ALU outputs are only meaningful in RESP; gate them so idle outputs read as zero.
    always_comb begin
        rsp_valid  = (state_q == RESP);
        rsp_id     = rsp_valid ? id_q : '0;
        rsp_result = rsp_valid ? alu_result : '0;
        rsp_zero   = rsp_valid & alu_zero;
        rsp_err    = 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
        if (rsp_valid && err_q) begin
            rsp_err    = 1'b1;
            rsp_result = '0;
            rsp_zero   = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural registered ALU (result, then zero one edge later).
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*3-1:0]     req_op;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_zero;
    logic                  rsp_err;
    logic [WIDTH-1:0]      alu_a, alu_b;
    logic [2:0]            alu_control;
    logic [WIDTH-1:0]      alu_result;
    logic                  alu_zero;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered ALU: result on one edge, zero derived from that result on the next.
    always @(posedge clk) begin
        case (alu_control)
            3'b000:  alu_result <= alu_a & alu_b;
            3'b001:  alu_result <= alu_a | alu_b;
            3'b010:  alu_result <= alu_a + alu_b;
            3'b110:  alu_result <= alu_a - alu_b;
            3'b111:  alu_result <= alu_a * alu_b;
            default: alu_result <= '0;
        endcase
        alu_zero <= (alu_result == '0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present one request at a negedge in IDLE, check it is granted, drop it after accept.
    task automatic send(input int idx, input logic [2:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b);
        req_op[3*idx +: 3]         = op;
        req_a[WIDTH*idx +: WIDTH]  = a;
        req_b[WIDTH*idx +: WIDTH]  = b;
        req_valid[idx]             = 1'b1;
        #1;
        chk("grant", req_ready, 64'(1 << idx));
        tick();
        req_valid[idx] = 1'b0;
    endtask

    // Called in the cycle after accept (cycle 1); lat counts cycles from the accept cycle.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 16) begin
            tick();
            lat++;
        end
    endtask

    task automatic expect_rsp(input string tag, input int exp_lat, input int exp_id,
                              input logic [WIDTH-1:0] res, input logic z, input logic e);
        int lat;
        wait_rsp(lat);
        chk({tag, "_lat"},    lat,        exp_lat);
        chk({tag, "_id"},     rsp_id,     exp_id);
        chk({tag, "_result"}, rsp_result, res);
        chk({tag, "_zero"},   rsp_zero,   z);
        chk({tag, "_err"},    rsp_err,    e);
        tick();
    endtask

    initial begin
        int prev;
        int w;
        int lat;
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) tick();

        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_zero", rsp_zero, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_control", alu_control, 0);
        rst = 1'b0;
        tick();

        // Single op, operand passthrough and 3-cycle latency.
        send(0, 3'b010, 32'd5, 32'd7);
        chk("add_alu_a", alu_a, 5);
        chk("add_alu_b", alu_b, 7);
        chk("add_alu_ctl", alu_control, 3'b010);
        chk("add_c1_valid", rsp_valid, 0);
        expect_rsp("add", 3, 0, 32'd12, 1'b0, 1'b0);

        // Zero flag must follow the current op.
        send(1, 3'b110, 32'd9, 32'd9);
        expect_rsp("sub", 3, 1, 32'd0, 1'b1, 1'b0);
        send(2, 3'b000, 32'hF0, 32'h0F);
        expect_rsp("and", 3, 2, 32'd0, 1'b1, 1'b0);
        send(3, 3'b001, 32'd1, 32'd0);
        expect_rsp("or", 3, 3, 32'd1, 1'b0, 1'b0);

        // Fairness: all valid, grant order 0,1,2,3,0 with one accept every 4 cycles.
        for (int k = 0; k < NREQ; k++) begin
            req_op[3*k +: 3]        = 3'b010;
            req_a[WIDTH*k +: WIDTH] = k;
            req_b[WIDTH*k +: WIDTH] = 32'd1;
        end
        req_valid = '1;
        #1;
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            w = 0;
            while (req_ready == '0 && w < 10) begin
                tick();
                w++;
            end
            chk("rr_gnt", req_ready, 64'(1 << (g % NREQ)));
            if (g > 0) chk("rr_gap", cyc - prev, 4);
            prev = cyc;
            tick();
            if (g == 4) req_valid = '0;
        end
        expect_rsp("rr_last", 3, 0, 32'd1, 1'b0, 1'b0);

        // Backpressure: response and blocked grant held for 10 cycles.
        rsp_ready = 1'b0;
        send(2, 3'b111, 32'd3, 32'd4);
        wait_rsp(lat);
        chk("bp_lat", lat, 3);
        req_a[0 +: WIDTH] = 32'd1;
        req_b[0 +: WIDTH] = 32'd1;
        req_valid[0]      = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_result", rsp_result, 12);
            chk("bp_ready", req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_released", rsp_valid, 0);
        chk("bp_next_gnt", req_ready, 4'b0001);
        tick();
        req_valid[0] = 1'b0;
        expect_rsp("bp_add", 3, 0, 32'd2, 1'b0, 1'b0);

        // Reset in FLAG: outputs clear, pointer returns so requester 0 beats 3.
        send(1, 3'b010, 32'd5, 32'd5);
        tick();
        chk("rst_mid_pre", rsp_valid, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstm_rsp_valid", rsp_valid, 0);
        chk("rstm_alu_a", alu_a, 0);
        chk("rstm_alu_b", alu_b, 0);
        chk("rstm_alu_ctl", alu_control, 0);
        chk("rstm_req_ready", req_ready, 0);
        chk("rstm_result", rsp_result, 0);
        req_valid = 4'b1001;
        #1;
        chk("rstm_gnt", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        expect_rsp("rstm_op", 3, 0, 32'd2, 1'b0, 1'b0);

        // Illegal opcode 3'b100.
        send(2, 3'b100, 32'd8, 32'd9);
`ifdef ALU_ARB_ILLEGAL_OP_EN
        expect_rsp("ill", 1, 2, 32'd0, 1'b1, 1'b1);
`else
        expect_rsp("ill", 3, 2, 32'd0, 1'b1, 1'b0);
`endif
        chk("ill_done", rsp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
